// File: rtl/synth_pkg.sv
// Shared definitions for the sample-to-DAC path.
//   SAMPLE_W / DAC_FRAME_W : sample and SPI frame widths
//   dac_state_e            : serializer FSM encoding
//   DAC_CONFIG_DEFAULT     : MCP4921 config nibble (A/B=0, BUF=0, GA_N=1, SHDN_N=1)
//   to_offset_binary()     : two's complement -> offset binary (MSB inverted)
package synth_pkg;

  localparam int SAMPLE_W    = 12;
  localparam int DAC_FRAME_W = 16;

  localparam logic [3:0] DAC_CONFIG_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } dac_state_e;

  function automatic logic [SAMPLE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SPI clock divider for the DAC serializer (mode 0, idle low).
//   clk_i      in   system clock
//   rst_i      in   synchronous active-high reset
//   en_i       in   count enable (only while shifting)
//   restart_i  in   force count and SCLK back to zero
//   sclk_o     out  SCLK level, toggles every CLK_DIV enabled cycles
//   rise_o     out  strike: SCLK rises on the coming clock edge
//   fall_o     out  strike: SCLK falls on the coming clock edge
module dac_sclk_gen import synth_pkg::*; #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             wrap;

  assign wrap   = en_i && (cnt_q == CNT_LAST);
  assign rise_o = wrap && !sclk_q;
  assign fall_o = wrap && sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (restart_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en_i) begin
      if (wrap) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/sample_dac_tx.sv
// Sample consumer driving an MCP4921-style 12-bit SPI DAC.
// Each 12-bit sample is sent as a 16-bit frame {CONFIG_BITS, sample}, MSB first.
// A one-entry pending buffer holds a sample that arrives while a frame is in flight.
//   inCLK_50MHZ    in   system clock
//   inRESET        in   synchronous active-high reset
//   inSample       in   12-bit sample, valid with inSampleReady
//   inSampleReady  in   1-cycle capture strobe
//   outDAC_CS_N    out  chip select, active low
//   outDAC_SCLK    out  SPI clock, mode 0
//   outDAC_MOSI    out  SPI data
//   outBusy        out  frame in flight (LOAD, SHIFT or CS-high gap)
//   outOverrun     out  1-cycle pulse when an unsent pending sample is overwritten
// Build option: define SAMPLE_DAC_TX_SIGN_CONV_EN to treat inSample as two's
// complement and convert it to offset binary before framing.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a strobe or pending sample
// LOAD  | build frame, drop CS_N, present first bit
// SHIFT | 16 SCLK periods, MOSI changes on falling edges
// GAP   | CS_N high for CS_HIGH_CYCLES before the next frame
module sample_dac_tx import synth_pkg::*; #(
  parameter int         CLK_DIV        = 2,
  parameter int         CS_HIGH_CYCLES = 4,
  parameter logic [3:0] CONFIG_BITS    = DAC_CONFIG_DEFAULT
) (
  input  logic                inCLK_50MHZ,
  input  logic                inRESET,
  input  logic [SAMPLE_W-1:0] inSample,
  input  logic                inSampleReady,
  output logic                outDAC_CS_N,
  output logic                outDAC_SCLK,
  output logic                outDAC_MOSI,
  output logic                outBusy,
  output logic                outOverrun
);

  localparam int GAP_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HIGH_CYCLES - 1);

  dac_state_e             state_q, state_d;
  logic [DAC_FRAME_W-1:0] shreg_q, shreg_d;
  logic [4:0]             bits_left_q, bits_left_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [SAMPLE_W-1:0]    sample_q, sample_d;
  logic [SAMPLE_W-1:0]    pend_q, pend_d;
  logic                   pend_vld_q, pend_vld_d;
  logic                   cs_n_q, cs_n_d;
  logic                   mosi_q, mosi_d;
  logic                   ovr_q, ovr_d;

  logic [SAMPLE_W-1:0]    sample_in;
  logic [DAC_FRAME_W-1:0] frame;
  logic                   sclk_rise, sclk_fall;
  logic                   gap_done, take_pend;

`ifdef SAMPLE_DAC_TX_SIGN_CONV_EN
  assign sample_in = to_offset_binary(inSample);
`else
  assign sample_in = inSample;
`endif

  dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk_i    (inCLK_50MHZ),
    .rst_i    (inRESET),
    .en_i     (state_q == ST_SHIFT),
    .restart_i(state_q == ST_LOAD),
    .sclk_o   (outDAC_SCLK),
    .rise_o   (sclk_rise),
    .fall_o   (sclk_fall)
  );

  assign frame     = {CONFIG_BITS, sample_q};
  assign gap_done  = (state_q == ST_GAP) && (gap_cnt_q == '0);
  // Pending is consumed whenever the FSM is about to enter LOAD from IDLE or GAP.
  assign take_pend = pend_vld_q && ((state_q == ST_IDLE) || gap_done);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    gap_cnt_d   = gap_cnt_q;
    sample_d    = sample_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    ovr_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (inSampleReady || pend_vld_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_d     = frame;
        bits_left_d = 5'(DAC_FRAME_W);
        cs_n_d      = 1'b0;
        mosi_d      = frame[DAC_FRAME_W-1];
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Bits are counted on rising edges; the fall after the last rise ends the frame.
        if (sclk_rise) bits_left_d = bits_left_q - 5'd1;
        if (sclk_fall) begin
          if (bits_left_q == 5'd0) begin
            cs_n_d    = 1'b1;
            mosi_d    = 1'b0;
            gap_cnt_d = GAP_LAST;
            state_d   = ST_GAP;
          end else begin
            shreg_d = {shreg_q[DAC_FRAME_W-2:0], 1'b0};
            mosi_d  = shreg_q[DAC_FRAME_W-2];
          end
        end
      end
      ST_GAP: begin
        if (gap_done) state_d = pend_vld_q ? ST_LOAD : ST_IDLE;
        else          gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_pend) begin
      // A strobe in the same cycle refills pending; nothing is lost, so no overrun.
      sample_d   = pend_q;
      pend_vld_d = inSampleReady;
      if (inSampleReady) pend_d = sample_in;
    end else if (inSampleReady) begin
      if (state_q == ST_IDLE) begin
        sample_d = sample_in;
      end else begin
        pend_d     = sample_in;
        pend_vld_d = 1'b1;
        ovr_d      = pend_vld_q;
      end
    end
  end

  always_ff @(posedge inCLK_50MHZ) begin
    if (inRESET) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      gap_cnt_q   <= '0;
      sample_q    <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      gap_cnt_q   <= gap_cnt_d;
      sample_q    <= sample_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      ovr_q       <= ovr_d;
    end
  end

  assign outDAC_CS_N = cs_n_q;
  assign outDAC_MOSI = mosi_q;
  assign outBusy     = (state_q != ST_IDLE);
  assign outOverrun  = ovr_q;

endmodule

// File: tb/tb_sample_dac_tx.sv
// Directed bench for sample_dac_tx at default parameters.
module tb_sample_dac_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] smp;
  logic        smp_rdy;
  logic        cs_n, sclk, mosi, busy, ovr;

  int checks = 0;
  int passes = 0;

  sample_dac_tx dut (
    .inCLK_50MHZ  (clk),
    .inRESET      (rst),
    .inSample     (smp),
    .inSampleReady(smp_rdy),
    .outDAC_CS_N  (cs_n),
    .outDAC_SCLK  (sclk),
    .outDAC_MOSI  (mosi),
    .outBusy      (busy),
    .outOverrun   (ovr)
  );

  always #10 clk = ~clk;

  // SPI monitor
  logic [15:0] mon_sr = '0;
  int          mon_bits = 0;
  int          rise_total = 0;
  logic [15:0] frames[$];
  int          frame_bits[$];

  always @(posedge sclk) begin
    rise_total++;
    if (cs_n === 1'b0) begin
      mon_sr = {mon_sr[14:0], mosi};
      mon_bits++;
    end
  end
  always @(negedge cs_n) begin
    mon_sr   = '0;
    mon_bits = 0;
  end
  always @(posedge cs_n) begin
    frames.push_back(mon_sr);
    frame_bits.push_back(mon_bits);
  end

  // Cycle bookkeeping, sampled mid-cycle
  int cyc = 0;
  int cs_low_cycles = 0;
  int hi_run = 0;
  int last_hi_run = 0;
  int ovr_cnt = 0;
  int ovr_cyc = -1;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (cs_n === 1'b0) begin
      cs_low_cycles++;
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
    end else begin
      hi_run++;
    end
    if (ovr === 1'b1) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic strobe(input logic [11:0] v);
    smp     = v;
    smp_rdy = 1'b1;
    tick();
    smp_rdy = 1'b0;
    smp     = '0;
  endtask

  task automatic clear_mon();
    frames.delete();
    frame_bits.delete();
    rise_total    = 0;
    cs_low_cycles = 0;
    ovr_cnt       = 0;
    ovr_cyc       = -1;
  endtask

  function automatic logic [15:0] frame_at(input int i);
    if (i < frames.size()) return frames[i];
    return 16'hxxxx;
  endfunction

  function automatic int bits_at(input int i);
    if (i < frame_bits.size()) return frame_bits[i];
    return -1;
  endfunction

  task automatic wait_frames_idle(input int n, input string tag);
    int k = 0;
    while ((frames.size() < n || busy !== 1'b0) && k < 600) begin
      tick();
      k++;
    end
    check(tag, 32'(frames.size() >= n && busy === 1'b0), 32'd1);
  endtask

  localparam logic [15:0] EXP_800 =
`ifdef SAMPLE_DAC_TX_SIGN_CONV_EN
    16'h3000;
`else
    16'h3800;
`endif
  localparam logic [15:0] EXP_7FF =
`ifdef SAMPLE_DAC_TX_SIGN_CONV_EN
    16'h3FFF;
`else
    16'h37FF;
`endif

  initial begin
    int k;
    int s3;
    rst     = 1'b1;
    smp     = '0;
    smp_rdy = 1'b0;

    // 1. reset then idle
    repeat (3) tick();
    rst = 1'b0;
    clear_mon();
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr",  32'(ovr),  32'd0);
    repeat (200) tick();
    check("idle_rises", 32'(rise_total), 32'd0);
    check("idle_cs_low", 32'(cs_low_cycles), 32'd0);

    // 2. single frame 12'hA5C
    clear_mon();
    strobe(12'hA5C);
    check("load_busy", 32'(busy), 32'd1);
    check("load_cs_n", 32'(cs_n), 32'd1);
    tick();
    check("lat_cs_low", 32'(cs_n), 32'd0);
    k = 1;
    while (busy === 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check("busy_len", 32'(k), 32'd69);
    check("f2_count", 32'(frames.size()), 32'd1);
    check("f2_frame", 32'(frame_at(0)), 32'h3A5C);
    check("f2_rises", 32'(rise_total), 32'd16);
    check("f2_cs_low", 32'(cs_low_cycles), 32'd64);

    // 3. sign-conversion corner values (expectation depends on build option)
    clear_mon();
    strobe(12'h800);
    wait_frames_idle(1, "f3a_timeout");
    check("f3_800", 32'(frame_at(0)), 32'(EXP_800));
    strobe(12'h7FF);
    wait_frames_idle(2, "f3b_timeout");
    check("f3_7ff", 32'(frame_at(1)), 32'(EXP_7FF));

    // 4. two strobes 10 cycles apart: back-to-back, no overrun
    tick();
    clear_mon();
    strobe(12'h111);
    repeat (9) tick();
    strobe(12'h222);
    wait_frames_idle(2, "f4_timeout");
    check("f4_frame0", 32'(frame_at(0)), 32'h3111);
    check("f4_frame1", 32'(frame_at(1)), 32'h3222);
    check("f4_bits1", 32'(bits_at(1)), 32'd16);
    check("f4_ovr", 32'(ovr_cnt), 32'd0);
    // CS stays high for the 4 GAP cycles plus the LOAD cycle of the next frame
    check("f4_cs_gap", 32'(last_hi_run), 32'd5);

    // 5. three strobes within one frame: middle sample overwritten
    tick();
    clear_mon();
    strobe(12'h111);
    repeat (4) tick();
    strobe(12'h222);
    repeat (4) tick();
    strobe(12'h333);
    s3 = cyc;
    wait_frames_idle(2, "f5_timeout");
    repeat (100) tick();
    check("f5_count", 32'(frames.size()), 32'd2);
    check("f5_frame0", 32'(frame_at(0)), 32'h3111);
    check("f5_frame1", 32'(frame_at(1)), 32'h3333);
    check("f5_ovr_cnt", 32'(ovr_cnt), 32'd1);
    check("f5_ovr_cyc", 32'(ovr_cyc), 32'(s3));

    // 6. reset at bit 7 with a sample pending
    clear_mon();
    strobe(12'hABC);
    repeat (3) tick();
    strobe(12'h555);
    k = 0;
    while (mon_bits < 8 && k < 200) begin
      tick();
      k++;
    end
    check("f6_reach_bit7", 32'(mon_bits), 32'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("f6_cs_n", 32'(cs_n), 32'd1);
    check("f6_sclk", 32'(sclk), 32'd0);
    check("f6_busy", 32'(busy), 32'd0);
    clear_mon();
    repeat (100) tick();
    check("f6_pend_clr", 32'(cs_low_cycles), 32'd0);
    strobe(12'h0F0);
    wait_frames_idle(1, "f6_timeout");
    check("f6_frame", 32'(frame_at(0)), 32'h30F0);
    check("f6_bits", 32'(bits_at(0)), 32'd16);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
